// File: rtl/mem_pkg.sv
// Shared memory-interface defaults and the request record carried through the queue.
package mem_pkg;

   localparam int MEM_DW = 32;
   localparam int MEM_AW = 16;

   typedef struct packed {
      logic              rw;
      logic [MEM_AW-1:0] addr;
      logic [MEM_DW-1:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/mem_req_fifo.sv
// In-order request queue; pointers wrap naturally because the depth is a power of two.
module mem_req_fifo
   import mem_pkg::*;
#(
   parameter int  P_DEPTH = 4,
   parameter type T       = mem_req_t,
   localparam int PW      = $clog2(P_DEPTH)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push,
   input  T            din,
   input  logic        pop,
   output T            dout,
   output logic        full,
   output logic        empty,
   output logic [PW:0] count
);

   T              store [P_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == (PW+1)'(P_DEPTH));
   assign empty   = (count == '0);
   assign dout    = store[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Entry storage carries data only, so it stays out of the reset domain.
   always_ff @(posedge clk) begin
      if (do_push) store[wr_ptr] <= din;
   end

endmodule

// File: rtl/mem_req_ctrl.sv
// Queues read/write requests and issues them in order to a single-cycle memory,
// holding each read result in a response register until the consumer takes it.
module mem_req_ctrl
   import mem_pkg::*;
#(
   parameter int P_MEM_DW     = MEM_DW,
   parameter int P_MEM_AW     = MEM_AW,
   parameter int P_FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_rw,
   input  logic [P_MEM_AW-1:0] req_addr,
   input  logic [P_MEM_DW-1:0] req_wdata,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [P_MEM_DW-1:0] rsp_rdata,
   output logic                m_cs,
   output logic                m_rw,
   output logic [P_MEM_AW-1:0] m_addr,
   output logic [P_MEM_DW-1:0] m_wdata,
   input  logic [P_MEM_DW-1:0] m_rdata
);

   localparam int CW = $clog2(P_FIFO_DEPTH) + 1;

   typedef struct packed {
      logic                rw;
      logic [P_MEM_AW-1:0] addr;
      logic [P_MEM_DW-1:0] wdata;
   } req_t;

   req_t          push_req;
   req_t          head;
   logic          full;
   logic          empty;
   logic [CW-1:0] count;
   logic          issue;
   logic [15:0]   wr_cnt;
   logic [15:0]   rd_cnt;
   logic          unused_ok;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign push_req = '{rw: req_rw, addr: req_addr, wdata: req_wdata};

   mem_req_fifo #(
      .P_DEPTH (P_FIFO_DEPTH),
      .T       (req_t)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (req_valid && req_ready),
      .din   (push_req),
      .pop   (issue),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   // Ready comes straight from the registered count, never from an input.
   assign req_ready = (count < CW'(P_FIFO_DEPTH));

   // A read at the head waits while the response register is still occupied;
   // anything behind it waits too, which keeps accesses strictly in order.
   assign issue = !empty && (!head.rw || !rsp_valid || rsp_ready);

   always_comb begin
      m_cs    = issue;
      m_rw    = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      if (issue) begin
         m_rw    = head.rw;
         m_addr  = head.addr;
         m_wdata = head.wdata;
      end
   end

   // Response register and issued-access counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         wr_cnt    <= '0;
         rd_cnt    <= '0;
      end else begin
         if (issue && head.rw) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= m_rdata;
         end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
         end
         if (issue) begin
            if (head.rw) rd_cnt <= sat_inc(rd_cnt);
            else         wr_cnt <= sat_inc(wr_cnt);
         end
      end
   end

   // Counters are debug probes only; fold them here so they count as read.
   assign unused_ok = ^{wr_cnt, rd_cnt, full};

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl with a behavioural single-cycle memory.
module tb_mem_req_ctrl;

   localparam int DW = 32;
   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic          req_rw;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          m_cs;
   logic          m_rw;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] m_rdata;

   always #5 clk = ~clk;

   mem_req_ctrl #(.P_MEM_DW(DW), .P_MEM_AW(AW), .P_FIFO_DEPTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_rw    (req_rw),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .m_cs      (m_cs),
      .m_rw      (m_rw),
      .m_addr    (m_addr),
      .m_wdata   (m_wdata),
      .m_rdata   (m_rdata)
   );

   // Memory model: combinational read, write on the rising edge.
   logic [DW-1:0] mem [0:65535];
   assign m_rdata = (m_cs && m_rw) ? mem[m_addr] : '0;
   always @(posedge clk) if (m_cs && !m_rw) mem[m_addr] <= m_wdata;

   // Record every accepted response and count memory selects.
   logic [DW-1:0] rsp_q [$];
   int unsigned   cs_cnt = 0;
   always @(posedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) rsp_q.push_back(rsp_rdata);
      if (m_cs) cs_cnt <= cs_cnt + 1;
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int n;
      req_valid = 1'b1;
      req_rw    = rw;
      req_addr  = a;
      req_wdata = d;
      n = 0;
      while (!req_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("push_ready", req_ready, 1);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int want);
      int k;
      k = 0;
      while (rsp_q.size() < want && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("rsp_wait", rsp_q.size() >= want, 1);
   endtask

   int            base;
   int            errs;
   int            sent;
   int            cyc;
   int            cur_a;
   logic          acc;
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] ref_mem [16];
   logic          wr_seen [16];
   int unsigned   cs0;

   initial begin
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_rw    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      rsp_ready = 1'b1;
      repeat (2) @(negedge clk);

      chk("rst_req_ready", req_ready, 1);
      chk("rst_m_cs", m_cs, 0);
      chk("rst_m_rw", m_rw, 0);
      chk("rst_m_addr", m_addr, 0);
      chk("rst_m_wdata", m_wdata, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Eight writes then eight reads, back to back.
      base = rsp_q.size();
      for (int i = 0; i < 8; i++) push(1'b0, AW'(i), DW'(i + 'h100));
      for (int i = 0; i < 8; i++) push(1'b1, AW'(i), '0);
      wait_rsp(base + 8);
      for (int i = 0; i < 8; i++) chk("b2b_rdata", rsp_q[base + i], DW'(i + 'h100));
      repeat (2) @(negedge clk);
      chk("b2b_wr_cnt", dut.wr_cnt, 8);
      chk("b2b_rd_cnt", dut.rd_cnt, 8);

      // Write then read one location; response one cycle wide.
      push(1'b0, 16'h0010, 32'hDEADBEEF);
      chk("wr_m_cs", m_cs, 1);
      chk("wr_m_rw", m_rw, 0);
      chk("wr_m_addr", m_addr, 16'h0010);
      chk("wr_m_wdata", m_wdata, 32'hDEADBEEF);
      push(1'b1, 16'h0010, '0);
      chk("rd_m_cs", m_cs, 1);
      chk("rd_m_rw", m_rw, 1);
      chk("rd_m_addr", m_addr, 16'h0010);
      chk("rd_rsp_valid_early", rsp_valid, 0);
      @(negedge clk);
      chk("rd_rsp_valid", rsp_valid, 1);
      chk("rd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      @(negedge clk);
      chk("rd_rsp_valid_drop", rsp_valid, 0);

      // Stalled consumer: fill the queue, hold a sixth request, then drain.
      for (int i = 0; i < 6; i++) push(1'b0, AW'('h40 + i), DW'('h1000 + i));
      repeat (3) @(negedge clk);
      rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) push(1'b1, AW'('h40 + i), '0);
      chk("full_req_ready", req_ready, 0);
      chk("full_count", dut.u_fifo.count, 4);
      chk("full_rsp_valid", rsp_valid, 1);
      chk("full_rsp_rdata", rsp_rdata, 32'h1000);
      chk("full_m_cs", m_cs, 0);
      req_valid = 1'b1;
      req_rw    = 1'b1;
      req_addr  = 16'h0045;
      repeat (2) @(negedge clk);
      chk("stall_rsp_rdata", rsp_rdata, 32'h1000);
      chk("stall_req_ready", req_ready, 0);
      chk("stall_m_cs", m_cs, 0);
      rsp_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("drain_rsp_valid", rsp_valid, 1);
         chk("drain_rsp_rdata", rsp_rdata, DW'('h1001 + i));
         if (i == 0) chk("drain_req_ready", req_ready, 1);
         if (i == 1) req_valid = 1'b0;
      end
      @(negedge clk);
      chk("drain_done", rsp_valid, 0);

      // Interleaved writes and reads to one address.
      base = rsp_q.size();
      push(1'b0, 16'h0020, 32'hA5A5A5A5);
      push(1'b1, 16'h0020, '0);
      push(1'b0, 16'h0020, 32'h5A5A5A5A);
      push(1'b1, 16'h0020, '0);
      wait_rsp(base + 2);
      chk("ilv_rsp0", rsp_q[base], 32'hA5A5A5A5);
      chk("ilv_rsp1", rsp_q[base + 1], 32'h5A5A5A5A);

      // Reset with three requests queued and a response pending.
      push(1'b0, 16'h0060, 32'h600);
      push(1'b0, 16'h0061, 32'h601);
      repeat (2) @(negedge clk);
      rsp_ready = 1'b0;
      push(1'b1, 16'h0040, '0);
      push(1'b1, 16'h0041, '0);
      push(1'b0, 16'h0060, 32'hBAD0);
      push(1'b0, 16'h0061, 32'hBAD1);
      chk("pre_rst_count", dut.u_fifo.count, 3);
      chk("pre_rst_rsp_valid", rsp_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_rsp_valid", rsp_valid, 0);
      chk("mid_rst_rsp_rdata", rsp_rdata, 0);
      chk("mid_rst_req_ready", req_ready, 1);
      chk("mid_rst_m_cs", m_cs, 0);
      chk("mid_rst_m_rw", m_rw, 0);
      chk("mid_rst_m_addr", m_addr, 0);
      chk("mid_rst_m_wdata", m_wdata, 0);
      chk("mid_rst_count", dut.u_fifo.count, 0);
      cs0 = cs_cnt;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_no_cs", cs_cnt, cs0);
      chk("post_rst_mem60", mem[16'h0060], 32'h600);
      chk("post_rst_mem61", mem[16'h0061], 32'h601);
      rsp_ready = 1'b1;

      // Random throttling against an in-order reference model.
      for (int i = 0; i < 16; i++) begin
         ref_mem[i] = '0;
         wr_seen[i] = 1'b0;
      end
      base = rsp_q.size();
      sent = 0;
      cyc  = 0;
      acc  = 1'b0;
      while ((sent < 1000 || (rsp_q.size() - base) < exp_q.size()) && cyc < 30000) begin
         @(negedge clk);
         cyc++;
         if (!req_valid || acc) begin
            acc = 1'b0;
            if (sent < 1000 && $urandom_range(0, 3) != 0) begin
               cur_a     = int'($urandom_range(0, 15));
               req_rw    = wr_seen[cur_a] ? 1'($urandom_range(0, 1)) : 1'b0;
               req_addr  = AW'('h80 + cur_a);
               req_wdata = $urandom;
               req_valid = 1'b1;
            end else begin
               req_valid = 1'b0;
            end
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         if (req_valid && req_ready) begin
            acc = 1'b1;
            sent++;
            if (req_rw) begin
               exp_q.push_back(ref_mem[req_addr[3:0]]);
            end else begin
               ref_mem[req_addr[3:0]] = req_wdata;
               wr_seen[req_addr[3:0]] = 1'b1;
            end
         end
      end
      @(negedge clk);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      repeat (6) @(negedge clk);
      chk("rand_sent", sent, 1000);
      chk("rand_rsp_count", rsp_q.size() - base, exp_q.size());
      errs = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
         if (base + i >= rsp_q.size() || rsp_q[base + i] !== exp_q[i]) errs++;
      end
      chk("rand_rsp_data", errs, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
